sdram_arbiter: RTL
==================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 3, giving the number of requesters (2..4).
REQ-002 SHALL have parameter REFRESH_LIMIT, default 519, giving the refresh threshold in cycles.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, NPORTS bits: per-port access request.
REQ-006 SHALL have port req_we, input, NPORTS bits: per-port direction, 1 = write, 0 = read.
REQ-007 SHALL have port req_ready, output, NPORTS bits: one-cycle accept pulse per port.
REQ-008 SHALL have port done, output, NPORTS bits: one-cycle completion pulse per port.
REQ-009 SHALL have port fsm_state, input, 5 bits: current state of the SDRAM command FSM.
REQ-010 SHALL have port rd_enable, output, 1 bit: read request to the FSM.
REQ-011 SHALL have port wr_enable, output, 1 bit: write request to the FSM.
REQ-012 SHALL have port refresh_cnt, output, 10 bits: cycles since the last refresh.
REQ-013 SHALL have port grant_id, output, 2 bits: index of the latched winner.
REQ-014 SHALL have port busy, output, 1 bit: high when the arbiter state is not ARB_IDLE.

Function
REQ-015 SHALL implement three states: ARB_IDLE, ARB_ISSUE, ARB_ACTIVE.
REQ-016 In ARB_IDLE, when any req_valid bit is set, SHALL latch a round-robin winner into grant_id, searching from last_grant+1 with wrap-around, and SHALL go to ARB_ISSUE.
REQ-017 In ARB_ISSUE, SHALL assert rd_enable = ~req_we[grant_id] or wr_enable = req_we[grant_id] combinationally, only while fsm_state == 5'b00000 and refresh_cnt < REFRESH_LIMIT; otherwise both are low.
REQ-018 The cycle in which an enable is asserted is the accept cycle: req_ready[grant_id] SHALL pulse high in that same cycle, and the state SHALL become ARB_ACTIVE.
REQ-019 In ARB_ISSUE, when refresh_cnt >= REFRESH_LIMIT, SHALL hold in ARB_ISSUE with the winner kept, so refresh has priority, and SHALL issue after the FSM returns to 5'b00000.
REQ-020 In ARB_ACTIVE, on the first cycle with fsm_state == 5'b00000, SHALL register done[grant_id] high for exactly one cycle (the next cycle), set last_grant = grant_id, and return to ARB_IDLE.
REQ-021 SHALL never assert rd_enable and wr_enable together, and SHALL assert neither outside ARB_ISSUE.
REQ-022 After acceptance, SHALL evaluate the winner's request from the latched grant_id and we; dropping req_valid after latching does not abort the access.
REQ-023 refresh_cnt SHALL increment by 1 each cycle, saturate at 1023, and clear to 0 on any cycle with fsm_state == 5'b00001 (refresh entry); the clear has priority over the increment.
REQ-024 At most one req_ready bit and at most one done bit SHALL be high in any cycle.

Reset
REQ-025 While RESET_N is low, SHALL immediately force: state ARB_IDLE, refresh_cnt 0, grant_id 0, last_grant NPORTS-1 (so port 0 wins first), done 0; rd_enable, wr_enable, req_ready and busy SHALL read 0.
REQ-026 Reset asserted mid-ARB_ACTIVE SHALL drop the access with no done pulse; operation resumes from ARB_IDLE after RESET_N rises.

Structure
REQ-027 Package sdram_pkg SHALL hold the FSM state codes (IDLE 5'b00000, REFRESH 5'b00001, RD_START 5'b10000, WR_START 5'b11000), REFRESH_LIMIT, and the arbiter state enum.
REQ-028 Round-robin selection SHALL be a combinational sub-module, rr_pick (inputs: request vector, last grant; outputs: winner index, any).

Verification
REQ-029 Single read: req_valid=001, req_we=000, fsm_state=0, refresh_cnt=10 -> rd_enable and req_ready[0] in the same cycle; fsm 10000..10100->00000 -> done[0] one cycle later.
REQ-030 Fairness: req_valid=111 held, FSM modeled -> accept order 0,1,2,0,1; no port starves.
REQ-031 Refresh priority: refresh_cnt reaches 519 while in ARB_ISSUE -> no enable; fsm_state=00001 -> refresh_cnt=0; FSM back at 00000 -> the held winner is issued.
REQ-032 Write: req_valid=010, req_we=010 -> wr_enable only, rd_enable stays 0, grant_id=1, then done[1].
REQ-033 Saturation: no refresh for 1100 cycles -> refresh_cnt holds 1023.
REQ-034 Reset in ARB_ACTIVE: RESET_N low -> busy=0 and refresh_cnt=0 immediately; no done pulse; the next request from port 0 is granted first.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbiter: command-FSM state codes, refresh threshold
// and arbiter state encoding.
package sdram_pkg;

  localparam logic [4:0] FsmIdle    = 5'b00000;
  localparam logic [4:0] FsmRefresh = 5'b00001;
  localparam logic [4:0] FsmRdStart = 5'b10000;
  localparam logic [4:0] FsmWrStart = 5'b11000;

  localparam int unsigned RefreshLimit = 519;
  localparam logic [9:0]  RefreshMax   = 10'h3ff;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbIssue,
    ArbActive
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after last+1, with wrap-around.
module rr_pick #(
  parameter int unsigned NPORTS = 3
) (
  input  logic [NPORTS-1:0] req,
  input  logic [1:0]        last,
  output logic [1:0]        winner,
  output logic              any
);

  always_comb begin
    logic [1:0] idx;
    winner = last;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned i = 1; i <= NPORTS; i++) begin
      idx = 2'((32'(last) + i) % NPORTS);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter feeding an SDRAM command FSM; defers issue while a refresh is due and
// tracks cycles since the last refresh.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NPORTS        = 3,
  parameter int unsigned REFRESH_LIMIT = RefreshLimit
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NPORTS-1:0] req_valid,
  input  logic [NPORTS-1:0] req_we,
  output logic [NPORTS-1:0] req_ready,
  output logic [NPORTS-1:0] done,
  input  logic [4:0]        fsm_state,
  output logic              rd_enable,
  output logic              wr_enable,
  output logic [9:0]        refresh_cnt,
  output logic [1:0]        grant_id,
  output logic              busy
);

  localparam logic [9:0] RefLimit = 10'(REFRESH_LIMIT);

  arb_state_e state_q;
  logic [1:0] last_grant;
  logic [1:0] pick_id;
  logic       pick_any;
  logic       issue_ok;

  rr_pick #(
    .NPORTS (NPORTS)
  ) u_rr_pick (
    .req    (req_valid),
    .last   (last_grant),
    .winner (pick_id),
    .any    (pick_any)
  );

  // Accept only with the command FSM idle and no refresh pending.
  assign issue_ok  = (state_q == ArbIssue) && (fsm_state == FsmIdle) &&
                     (refresh_cnt < RefLimit);
  assign rd_enable = issue_ok & ~req_we[grant_id];
  assign wr_enable = issue_ok &  req_we[grant_id];
  assign busy      = (state_q != ArbIdle);

  always_comb begin
    req_ready           = '0;
    req_ready[grant_id] = issue_ok;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ArbIdle;
      refresh_cnt <= '0;
      grant_id    <= '0;
      last_grant  <= 2'(NPORTS - 1);
      done        <= '0;
    end else begin
      done <= '0;

      if (fsm_state == FsmRefresh) begin
        refresh_cnt <= '0;
      end else if (refresh_cnt != RefreshMax) begin
        refresh_cnt <= refresh_cnt + 10'd1;
      end

      unique case (state_q)
        ArbIdle: begin
          if (pick_any) begin
            grant_id <= pick_id;
            state_q  <= ArbIssue;
          end
        end
        ArbIssue: begin
          if (issue_ok) begin
            state_q <= ArbActive;
          end
        end
        ArbActive: begin
          if (fsm_state == FsmIdle) begin
            done[grant_id] <= 1'b1;
            last_grant     <= grant_id;
            state_q        <= ArbIdle;
          end
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

endmodule
